// File: rtl/bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : bus_responder
// Brief    : Completes a decoded CPU bus access by sending a one-hot device request, waiting for ready or timeout, then returning data with an ack/err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module bus_responder #(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [2:0]          cpu_sel,
   input  logic [15:0]         cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   output logic [DATA_W-1:0]   cpu_rdata,
   output logic                cpu_ack,
   output logic                cpu_err,
   output logic                cpu_busy,
   output logic [3:0]          dev_req,
   output logic                dev_we,
   output logic [15:0]         dev_addr,
   output logic [DATA_W-1:0]   dev_wdata,
   input  logic [4*DATA_W-1:0] dev_rdata,
   input  logic [3:0]          dev_ready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);
   localparam logic [7:0] c_cnt_max      = 8'hFF;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [1:0]          r_idx;
   logic [1:0]          w_idx_nxt;
   logic [7:0]          r_cnt;
   logic [7:0]          w_cnt_nxt;
   logic [3:0]          r_dev_req;
   logic [3:0]          w_dev_req_nxt;
   logic                r_dev_we;
   logic                w_dev_we_nxt;
   logic [15:0]         r_dev_addr;
   logic [15:0]         w_dev_addr_nxt;
   logic [DATA_W-1:0]   r_dev_wdata;
   logic [DATA_W-1:0]   w_dev_wdata_nxt;
   logic [DATA_W-1:0]   r_cpu_rdata;
   logic [DATA_W-1:0]   w_cpu_rdata_nxt;
   logic                r_ack;
   logic                w_ack_nxt;
   logic                r_err;
   logic                w_err_nxt;
   logic                r_busy;
   logic                w_busy_nxt;

   logic [1:0]          w_sel_idx;
   logic                w_sel_mapped;
   logic                w_ready;
   logic [DATA_W-1:0]   w_rdata_arr [4];

   genvar k;
   generate
      for (k = 0; k < 4; k++) begin : g_rdata_slice
         assign w_rdata_arr[k] = dev_rdata[DATA_W*k +: DATA_W];
      end
   endgenerate

   // Selects 1..4 wrap to device index 0..3 in their low two bits.
   assign w_sel_idx    = cpu_sel[1:0] - 2'd1;
   assign w_sel_mapped = (cpu_sel >= 3'd1) && (cpu_sel <= 3'd4);
   assign w_ready      = dev_ready[r_idx];

   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_cnt_nxt       = r_cnt;
      w_dev_req_nxt   = r_dev_req;
      w_dev_we_nxt    = r_dev_we;
      w_dev_addr_nxt  = r_dev_addr;
      w_dev_wdata_nxt = r_dev_wdata;
      w_cpu_rdata_nxt = r_cpu_rdata;
      w_ack_nxt       = 1'b0;
      w_err_nxt       = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (cpu_req) begin
               w_dev_we_nxt    = cpu_we;
               w_dev_addr_nxt  = cpu_addr;
               w_dev_wdata_nxt = cpu_wdata;
               w_idx_nxt       = w_sel_idx;
               if (w_sel_mapped) begin
                  w_state_nxt   = S_WAIT;
                  w_dev_req_nxt = 4'b0001 << w_sel_idx;
                  w_cnt_nxt     = 8'd0;
               end else begin
                  w_state_nxt = S_ERR;
                  w_ack_nxt   = 1'b1;
                  w_err_nxt   = 1'b1;
               end
            end
         end

         S_WAIT: begin
            // Ready is checked first so it beats a coincident timeout.
            if (w_ready) begin
               w_state_nxt   = S_RESP;
               w_dev_req_nxt = 4'b0000;
               w_ack_nxt     = 1'b1;
               if (!r_dev_we) begin
                  w_cpu_rdata_nxt = w_rdata_arr[r_idx];
               end
            end else if (r_cnt == c_timeout_last) begin
               w_state_nxt   = S_ERR;
               w_dev_req_nxt = 4'b0000;
               w_ack_nxt     = 1'b1;
               w_err_nxt     = 1'b1;
            end else if (r_cnt != c_cnt_max) begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end

         S_RESP: w_state_nxt = S_IDLE;

         S_ERR:  w_state_nxt = S_IDLE;

         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_busy_nxt = (w_state_nxt != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_idx       <= 2'd0;
         r_cnt       <= 8'd0;
         r_dev_req   <= 4'b0000;
         r_dev_we    <= 1'b0;
         r_dev_addr  <= 16'd0;
         r_dev_wdata <= '0;
         r_cpu_rdata <= '0;
         r_ack       <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_cnt       <= w_cnt_nxt;
         r_dev_req   <= w_dev_req_nxt;
         r_dev_we    <= w_dev_we_nxt;
         r_dev_addr  <= w_dev_addr_nxt;
         r_dev_wdata <= w_dev_wdata_nxt;
         r_cpu_rdata <= w_cpu_rdata_nxt;
         r_ack       <= w_ack_nxt;
         r_err       <= w_err_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign cpu_rdata = r_cpu_rdata;
   assign cpu_ack   = r_ack;
   assign cpu_err   = r_err;
   assign cpu_busy  = r_busy;
   assign dev_req   = r_dev_req;
   assign dev_we    = r_dev_we;
   assign dev_addr  = r_dev_addr;
   assign dev_wdata = r_dev_wdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_responder
// Brief    : Randomized transaction bench for bus_responder with a per-cycle expected-output timeline derived from transaction latency rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_responder;

   localparam int DW = 16;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            cpu_req;
   logic            cpu_we;
   logic [2:0]      cpu_sel;
   logic [15:0]     cpu_addr;
   logic [DW-1:0]   cpu_wdata;
   logic [DW-1:0]   cpu_rdata;
   logic            cpu_ack;
   logic            cpu_err;
   logic            cpu_busy;
   logic [3:0]      dev_req;
   logic            dev_we;
   logic [15:0]     dev_addr;
   logic [DW-1:0]   dev_wdata;
   logic [4*DW-1:0] dev_rdata;
   logic [3:0]      dev_ready;

   bus_responder #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
      .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr),
      .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ready(dev_ready)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last_ack = -100;
   logic ack_err = 1'b0;
   bit chk_on = 1'b0;

   // Expected DUT outputs for the current cycle
   logic          exp_busy, exp_ack, exp_err, exp_we;
   logic [3:0]    exp_req;
   logic [15:0]   exp_addr;
   logic [DW-1:0] exp_wdata, exp_rdata;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cpu_ack === 1'b1) begin
         last_ack <= cyc;
         ack_err  <= cpu_err;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy",  64'(cpu_busy),  64'(exp_busy));
         chk("ack",   64'(cpu_ack),   64'(exp_ack));
         chk("err",   64'(cpu_err),   64'(exp_err));
         chk("req",   64'(dev_req),   64'(exp_req));
         chk("we",    64'(dev_we),    64'(exp_we));
         chk("addr",  64'(dev_addr),  64'(exp_addr));
         chk("wdata", 64'(dev_wdata), 64'(exp_wdata));
         chk("rdata", 64'(cpu_rdata), 64'(exp_rdata));
      end
   end

   task automatic set_idle_exp();
      exp_busy = 1'b0;
      exp_ack  = 1'b0;
      exp_err  = 1'b0;
      exp_req  = 4'b0000;
   endtask

   // Random data on every device; the addressed one carries rval and rdy.
   task automatic drive_dev(input logic [1:0] idx, input bit mapped,
                            input logic [DW-1:0] rval, input bit rdy);
      dev_rdata = {$urandom, $urandom};
      dev_ready = 4'($urandom_range(0, 15));
      if (mapped) begin
         dev_rdata[DW*idx +: DW] = rval;
         dev_ready[idx] = rdy;
      end
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      set_idle_exp();
      cpu_req = 1'b0;
      drive_dev(2'd0, 1'b0, '0, 1'b0);
   endtask

   // One transaction; expected outputs follow from its total latency:
   // unmapped 1, timeout TO+1, otherwise n_wait+2 cycles to the ack.
   task automatic do_txn(input logic [2:0] sel, input logic we, input logic [15:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] rval,
                         input int n_wait, input int glitch_c, output int lat_meas);
      bit mapped, tmo;
      int lat, req_edge;
      logic [1:0] idx;
      logic [3:0] oh;
      mapped = (sel >= 3'd1) && (sel <= 3'd4);
      idx    = 2'(sel - 3'd1);
      oh     = mapped ? (4'b0001 << idx) : 4'b0000;
      tmo    = mapped && (n_wait >= TO);
      lat    = !mapped ? 1 : (tmo ? TO + 1 : n_wait + 2);
      req_edge = 0;
      cpu_req = 1'b1; cpu_we = we; cpu_sel = sel; cpu_addr = addr; cpu_wdata = wdata;
      drive_dev(idx, mapped, rval, 1'b0);
      for (int c = 1; c <= lat; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            req_edge  = cyc;
            exp_we    = we;
            exp_addr  = addr;
            exp_wdata = wdata;
         end
         exp_busy = 1'b1;
         exp_ack  = (c == lat);
         exp_err  = exp_ack && (!mapped || tmo);
         exp_req  = (c < lat) ? oh : 4'b0000;
         if (c == lat && mapped && !tmo && !we) exp_rdata = rval;
         cpu_req = 1'b0;
         if (c == glitch_c && c < lat) begin
            cpu_req   = 1'b1;
            cpu_sel   = 3'($urandom_range(0, 7));
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 16'($urandom);
            cpu_wdata = DW'($urandom);
         end
         drive_dev(idx, mapped, rval, mapped && (c == n_wait + 1));
      end
      @(posedge clk); #1;
      set_idle_exp();
      cpu_req = 1'b0;
      drive_dev(2'd0, 1'b0, '0, 1'b0);
      lat_meas = last_ack - req_edge + 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_sel = 3'd0;
      cpu_addr = 16'd0; cpu_wdata = '0; dev_rdata = '0; dev_ready = 4'b0;
      set_idle_exp();
      exp_we = 1'b0; exp_addr = 16'd0; exp_wdata = '0; exp_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_on = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) idle_cycle();

      // Directed cases with literal latency/data expectations
      do_txn(3'd2, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0, 0, lat);
      chk("lit_rd_lat", 64'(lat), 64'd2);
      chk("lit_rd_data", 64'(cpu_rdata), 64'hBEEF);
      do_txn(3'd3, 1'b1, 16'h0004, 16'h1234, 16'h5A5A, 3, 0, lat);
      chk("lit_wr_lat", 64'(lat), 64'd5);
      chk("lit_wr_rdata_kept", 64'(cpu_rdata), 64'hBEEF);
      chk("lit_wr_addr", 64'(dev_addr), 64'h0004);
      chk("lit_wr_wdata", 64'(dev_wdata), 64'h1234);
      do_txn(3'd0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 0, 0, lat);
      chk("lit_sel0_lat", 64'(lat), 64'd1);
      chk("lit_sel0_err", 64'(ack_err), 64'd1);
      do_txn(3'd7, 1'b1, 16'h0200, 16'hFFFF, 16'h0000, 0, 0, lat);
      chk("lit_sel7_lat", 64'(lat), 64'd1);
      do_txn(3'd4, 1'b0, 16'h0300, 16'h0000, 16'hCAFE, TO, 0, lat);
      chk("lit_tmo_lat", 64'(lat), 64'd17);
      chk("lit_tmo_err", 64'(ack_err), 64'd1);
      chk("lit_tmo_rdata_kept", 64'(cpu_rdata), 64'hBEEF);
      do_txn(3'd4, 1'b0, 16'h0300, 16'h0000, 16'hCAFE, TO - 1, 0, lat);
      chk("lit_last_wait_lat", 64'(lat), 64'd17);
      chk("lit_last_wait_err", 64'(ack_err), 64'd0);
      chk("lit_last_wait_data", 64'(cpu_rdata), 64'hCAFE);
      do_txn(3'd1, 1'b0, 16'h0040, 16'h0000, 16'h1111, 4, 2, lat);
      chk("lit_glitch_lat", 64'(lat), 64'd6);

      // Reset during the second WAIT cycle aborts the access silently
      cpu_req = 1'b1; cpu_sel = 3'd1; cpu_we = 1'b0; cpu_addr = 16'h0ABC; cpu_wdata = 16'h5555;
      drive_dev(2'd0, 1'b1, 16'h7777, 1'b0);
      @(posedge clk); #1;
      exp_busy = 1'b1; exp_req = 4'b0001; exp_we = 1'b0; exp_addr = 16'h0ABC; exp_wdata = 16'h5555;
      cpu_req = 1'b0;
      drive_dev(2'd0, 1'b1, 16'h7777, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      drive_dev(2'd0, 1'b1, 16'h7777, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      set_idle_exp();
      exp_we = 1'b0; exp_addr = 16'd0; exp_wdata = '0; exp_rdata = '0;
      @(negedge clk);
      chk("lit_rst_req", 64'(dev_req), 64'd0);
      chk("lit_rst_busy", 64'(cpu_busy), 64'd0);
      repeat (3) idle_cycle();
      do_txn(3'd1, 1'b0, 16'h0008, 16'h0000, 16'h2468, 1, 0, lat);
      chk("lit_post_rst_lat", 64'(lat), 64'd3);
      chk("lit_post_rst_data", 64'(cpu_rdata), 64'h2468);

      // Randomized traffic
      for (int i = 0; i < 250; i++) begin
         int r, nw, gl;
         r = int'($urandom_range(0, 9));
         if (r < 7)       nw = int'($urandom_range(0, 4));
         else if (r == 7) nw = TO - 1;
         else if (r == 8) nw = TO;
         else             nw = TO + int'($urandom_range(1, 5));
         gl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         do_txn(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
                DW'($urandom), DW'($urandom), nw, gl, lat);
         repeat ($urandom_range(0, 2)) idle_cycle();
      end

      idle_cycle();
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
